test_bed: RTL and testbench
===========================

# test_bed

Self-checking result monitor sitting beside the CHIP on the processor-side data-cache write port. It watches every word the processor writes toward its data cache, compares writes to a result window against an expected-answer table, and counts mismatches. It measures the run length in cycles and raises `finish` when the program writes the end marker. It observes only and never drives CHIP or memory signals.

## Interface

Parameters:
- `ANS_NUM`, 8: number of expected result words, 1..255.
- `BASE_ADDR`, 30'd64: word address of result slot 0; slot k is at `BASE_ADDR + k`.
- `END_ADDR`, 30'd255: word address whose write signals program end; lies outside the result window.

Ports:
- `clk`, in, 1: system clock, rising-edge.
- `rst`, in, 1: reset, asynchronous, active-low (driven by system `rst_n`).
- `addr`, in, 30: word address of the processor D-cache access.
- `data`, in, 32: processor write data.
- `wen`, in, 1: write enable; a write is valid on any rising edge where `wen`=1.
- `error_num`, out, 8: count of mismatched or missing results; saturates at 255.
- `duration`, out, 16: cycles elapsed since reset release; saturates at 16'hFFFF.
- `finish`, out, 1: end of run; sticky until reset.

## Operation

- Reset (`rst`=0, asynchronous): set `error_num`=0, `duration`=0, `finish`=0, slot index `idx`=0, state RUN.
- States:
  - RUN: active checking.
  - DONE: entered on the end-marker write; stays until reset.
- Writes in RUN with `wen`=1:
  - `addr == BASE_ADDR + idx` and `idx < ANS_NUM`: compare `data` with `ans[idx]`.
    - On mismatch, `error_num` += 1 (saturating) and the simulation prints slot, expected value and received value.
    - `idx` += 1 in both the match and mismatch case.
  - Other addresses in the window, including rewrites of already-checked slots: ignored.
  - `addr == END_ADDR`: `error_num` += (`ANS_NUM` − `idx`), saturating at 255, to count missing results; then `finish`=1 and go to DONE.
  - All other addresses: ignored.
- DONE:
  - All writes ignored.
  - `error_num`, `duration` and `finish` frozen.
- Answer table `ans[k]` for k < `ANS_NUM`: default `ans[k] = k + 1`. Each program variant supplies its own table.

## Timing

- All outputs are registered; an event sampled at rising edge N is visible after edge N.
- `duration` increments on every rising edge while `rst`=1 and `finish`=0.
  - The edge that samples the end-marker write also increments `duration`.
  - `finish` is 1 from that same edge onward.
- One write is checked per cycle; consecutive-cycle writes are all checked.
- A mismatch and a later end marker in consecutive cycles accumulate both contributions.
- Reset asserted mid-run clears everything immediately, regardless of state.

## Structure

- Shared package `test_bed_pkg`:
  - width constants: 30-bit address, 32-bit data, 8-bit error count, 16-bit duration;
  - default `BASE_ADDR` and `END_ADDR`;
  - state encoding RUN/DONE.
- One sub-module, `test_bed_answer_rom`:
  - combinational lookup indexed by `idx`, returning `ans[idx]`;
  - table selected by parameter so each program variant swaps only this ROM.

## Test plan

- Reset only, 100 cycles after release, no writes -> `duration`=100, `error_num`=0, `finish`=0.
- Correct results, default parameters:
  - stimulus: write data k+1 to addr 64+k for k=0..7, then write to addr 255 at cycle 20;
  - required: `error_num`=0, `finish`=1 from that edge, `duration`=20 and frozen afterward.
- Mismatches:
  - stimulus: slot 2 written 32'hDEAD_BEEF, slot 5 written 0, all other slots correct, then end marker;
  - required: `error_num`=2.
- Missing results:
  - stimulus: only slots 0..4 written correctly, then end marker;
  - required: `error_num`=3, `finish`=1.
- Out-of-order and ignored writes:
  - stimulus: write slot 3 before slot 0, plus writes to addr 10;
  - required: the early slot-3 write is ignored; the in-order sequence then yields `error_num`=0 at end.
- Reset mid-run, issued after 2 errors and `finish`=1 -> all outputs 0 immediately; the next correct run reports `error_num`=0.

Source files
------------

// File: rtl/test_bed_pkg.sv
// Shared widths, default addresses, FSM encoding and the saturating error
// accumulator used by the result monitor.
package test_bed_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 8;
  localparam int DUR_W  = 16;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 30'd64;
  localparam logic [ADDR_W-1:0] END_ADDR_DEF  = 30'd255;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // One extra carry bit is enough: 255 + 255 still fits in ERR_W+1 bits.
  function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] a,
                                                   input logic [ERR_W-1:0] b);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/test_bed_if.sv
// Processor D-cache write port as seen by the monitor.
// wen is a one-cycle valid with no ready: every edge with wen=1 is a write
// and the monitor always accepts it; addr/data are meaningful only then.
interface test_bed_if;
  logic [test_bed_pkg::ADDR_W-1:0] addr;
  logic [test_bed_pkg::DATA_W-1:0] data;
  logic                            wen;

  modport master (output addr, output data, output wen);
  modport slave  (input  addr, input  data, input  wen);
endinterface

// File: rtl/test_bed_answer_rom.sv
// Expected-answer table; each program variant selects its table with TABLE.
module test_bed_answer_rom
  import test_bed_pkg::*;
#(
  parameter int TABLE = 0
) (
  input  logic [ERR_W-1:0]  idx,
  output logic [DATA_W-1:0] ans
);

  always_comb begin
    ans = '0;
    case (TABLE)
      1:       ans = 32'hA5A5_0000 ^ {{(DATA_W-ERR_W){1'b0}}, idx};
      default: ans = {{(DATA_W-ERR_W){1'b0}}, idx} + 32'd1;
    endcase
  end

endmodule

// File: rtl/test_bed.sv
// Result monitor: checks in-order writes to the result window against the
// answer ROM, counts mismatches and missing slots, and times the run.
module test_bed
  import test_bed_pkg::*;
#(
  parameter int                ANS_NUM   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [ADDR_W-1:0] END_ADDR  = END_ADDR_DEF,
  parameter int                ANS_TABLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  test_bed_if.slave        bus,
  output logic [ERR_W-1:0] error_num,
  output logic [DUR_W-1:0] duration,
  output logic             finish,
  output state_e           dbg_state
);

  localparam logic [ERR_W-1:0] ANS_NUM_C = ERR_W'(ANS_NUM);

  state_e             state_q, state_d;
  logic [ERR_W-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               fin_q, fin_d;
  logic [DATA_W-1:0]  ans;
  logic [ADDR_W-1:0]  slot_addr;

  test_bed_answer_rom #(.TABLE(ANS_TABLE)) u_rom (
    .idx (idx_q),
    .ans (ans)
  );

  assign slot_addr = BASE_ADDR + ADDR_W'(idx_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      err_q   <= '0;
      dur_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      dur_q   <= dur_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    dur_d   = dur_q;
    fin_d   = fin_q;
    case (state_q)
      ST_RUN: begin
        // The end-marker edge still counts toward the run length.
        if (dur_q != {DUR_W{1'b1}}) dur_d = dur_q + 1'b1;
        if (bus.wen) begin
          if (bus.addr == END_ADDR) begin
            err_d   = err_sat_add(err_q, ANS_NUM_C - idx_q);
            fin_d   = 1'b1;
            state_d = ST_DONE;
          end else if ((idx_q < ANS_NUM_C) && (bus.addr == slot_addr)) begin
            idx_d = idx_q + 1'b1;
            if (bus.data != ans) err_d = err_sat_add(err_q, 8'd1);
          end
        end
      end
      default: ;
    endcase
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign finish    = fin_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_test_bed.sv
// Directed and randomized checks of the result monitor against a
// transaction-level model of the expected-answer rules.
module tb_test_bed;
  import test_bed_pkg::*;

  localparam int          N_ANS = 8;
  localparam logic [29:0] BASE  = 30'd64;
  localparam logic [29:0] ENDA  = 30'd255;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;
  state_e      dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  wr_t         run_q[$];
  logic [31:0] exp_q[$];

  test_bed_if bus ();

  test_bed dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .error_num (error_num),
    .duration  (duration),
    .finish    (finish),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_word(input logic [29:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.data = d;
    bus.wen  = 1'b1;
    tick();
    bus.wen  = 1'b0;
  endtask

  task automatic do_reset();
    bus.wen = 1'b0;
    rst     = 1'b0;
    idle(2);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic write_correct(input int k);
    write_word(BASE + 30'(k), 32'(k + 1));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: walk the write list as the program would be graded
  function automatic int model_errors();
    int next = 0;
    int errs = 0;
    foreach (run_q[i]) begin
      if (run_q[i].a == ENDA) begin
        errs += N_ANS - next;
        return (errs > 255) ? 255 : errs;
      end
      if (next < N_ANS && run_q[i].a == BASE + 30'(next)) begin
        if (run_q[i].d != 32'(next + 1)) errs++;
        next++;
      end
    end
    return -1;
  endfunction

  task automatic build_random_run();
    int stop;
    run_q.delete();
    stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N_ANS - 1) : N_ANS;
    for (int k = 0; k < stop; k++) begin
      wr_t w;
      case ($urandom_range(0, 5))
        0: begin w.a = 30'($urandom_range(0, 254)); w.d = $urandom; run_q.push_back(w); end
        1: begin w.a = BASE + 30'($urandom_range(k + 1, N_ANS - 1)); w.d = 32'(k + 2); run_q.push_back(w); end
        2: if (k > 0) begin w.a = BASE + 30'($urandom_range(0, k - 1)); w.d = $urandom; run_q.push_back(w); end
        default: ;
      endcase
      w.a = BASE + 30'(k);
      w.d = ($urandom_range(0, 3) == 0) ? $urandom : 32'(k + 1);
      run_q.push_back(w);
    end
    begin
      wr_t e;
      e.a = ENDA;
      e.d = $urandom;
      run_q.push_back(e);
    end
  endtask

  task automatic play_run(output int end_cyc);
    end_cyc = 0;
    foreach (run_q[i]) begin
      idle($urandom_range(0, 2));
      write_word(run_q[i].a, run_q[i].d);
      if (run_q[i].a == ENDA) end_cyc = cyc;
    end
  endtask

  initial begin
    int exp_err;
    int end_cyc;
    bus.addr = '0;
    bus.data = '0;
    bus.wen  = 1'b0;

    // reset only
    idle(2);
    check("reset_err", 32'(error_num), 32'd0);
    check("reset_dur", 32'(duration), 32'd0);
    check("reset_fin", 32'(finish), 32'd0);
    rst = 1'b1;
    cyc = 0;
    idle(100);
    check("idle100_dur", 32'(duration), 32'd100);
    check("idle100_err", 32'(error_num), 32'd0);
    check("idle100_fin", 32'(finish), 32'd0);

    // correct results, end marker on edge 20
    do_reset();
    for (int k = 0; k < N_ANS; k++) write_correct(k);
    idle(11);
    check("good_fin_before", 32'(finish), 32'd0);
    check("good_dur_19", 32'(duration), 32'd19);
    write_word(ENDA, 32'd0);
    check("good_fin", 32'(finish), 32'd1);
    check("good_dur_20", 32'(duration), 32'd20);
    check("good_err", 32'(error_num), 32'd0);
    write_word(BASE, 32'hBAD);
    idle(10);
    check("good_dur_frozen", 32'(duration), 32'd20);
    check("good_err_frozen", 32'(error_num), 32'd0);
    check("good_fin_sticky", 32'(finish), 32'd1);

    // two mismatches, marker written right after the last slot
    do_reset();
    for (int k = 0; k < N_ANS; k++) begin
      if (k == 2)      write_word(BASE + 30'd2, 32'hDEAD_BEEF);
      else if (k == 5) write_word(BASE + 30'd5, 32'd0);
      else             write_correct(k);
    end
    write_word(ENDA, 32'd0);
    check("mism_err", 32'(error_num), 32'd2);
    check("mism_fin", 32'(finish), 32'd1);

    // reset mid-run clears outputs without waiting for an edge
    rst = 1'b0;
    #1;
    check("async_rst_err", 32'(error_num), 32'd0);
    check("async_rst_dur", 32'(duration), 32'd0);
    check("async_rst_fin", 32'(finish), 32'd0);
    do_reset();
    for (int k = 0; k < N_ANS; k++) write_correct(k);
    write_word(ENDA, 32'd0);
    check("after_rst_err", 32'(error_num), 32'd0);
    check("after_rst_fin", 32'(finish), 32'd1);

    // missing results
    do_reset();
    for (int k = 0; k < 5; k++) write_correct(k);
    write_word(ENDA, 32'd0);
    check("missing_err", 32'(error_num), 32'd3);
    check("missing_fin", 32'(finish), 32'd1);

    // mismatch immediately followed by the end marker
    do_reset();
    write_correct(0);
    write_word(BASE + 30'd1, 32'd77);
    write_word(ENDA, 32'd0);
    check("mism_then_end_err", 32'(error_num), 32'd7);
    check("mism_then_end_dur", 32'(duration), 32'd3);

    // out-of-order and ignored writes
    do_reset();
    write_word(BASE + 30'd3, 32'd4);
    write_word(30'd10, 32'h1234);
    for (int k = 0; k < N_ANS; k++) begin
      write_correct(k);
      if (k == 1) write_word(30'd10, 32'd0);
      if (k == 4) write_word(BASE, 32'hFFFF_FFFF);
    end
    check("ooo_err_before_end", 32'(error_num), 32'd0);
    write_word(ENDA, 32'd0);
    check("ooo_err", 32'(error_num), 32'd0);

    // randomized runs against the model
    for (int r = 0; r < 25; r++) begin
      do_reset();
      build_random_run();
      exp_err = model_errors();
      play_run(end_cyc);
      exp_q.push_back(32'(exp_err));
      exp_q.push_back(32'd1);
      exp_q.push_back(32'(end_cyc));
      idle($urandom_range(0, 4));
      check("rand_err", 32'(error_num), exp_q.pop_front());
      check("rand_fin", 32'(finish), exp_q.pop_front());
      check("rand_dur", 32'(duration), exp_q.pop_front());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
